// File: rtl/led_seq_ctrl.sv
// LED bar sequencer: synchronized and debounced switches select one of four
// patterns stepped by a programmable tick. Define LED_PWM_EN to add brightness PWM.
module led_seq_ctrl #(
  parameter int TICK_DIV   = 5000000,
  parameter int DEB_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  output logic [15:0] ledr,
  output logic        tick,
  output logic [1:0]  mode
);

  localparam logic [1:0] ST_ROT_L  = 2'd0;
  localparam logic [1:0] ST_ROT_R  = 2'd1;
  localparam logic [1:0] ST_BOUNCE = 2'd2;
  localparam logic [1:0] ST_BLINK  = 2'd3;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

  logic [7:0]       sync1, sync2, cand, sw_db;
  logic [DEB_W-1:0] deb_cnt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      limit, limit_m1;
  logic [7:0]       led, led_out;
  logic             dir_left;
  logic             mode_chg;

  function automatic logic [7:0] init_pattern(input logic [1:0] m);
    case (m)
      ST_ROT_L:  return 8'h01;
      ST_ROT_R:  return 8'h80;
      ST_BOUNCE: return 8'h01;
      default:   return 8'hFF;
    endcase
  endfunction

  // deb_cnt counts consecutive cycles the synced value has matched cand,
  // including the cycle it first appeared, and saturates at DEB_CYCLES.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      deb_cnt <= '0;
      sw_db   <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand    <= sync2;
        deb_cnt <= DEB_W'(1);
        if (DEB_CYCLES == 1) sw_db <= sync2;
      end else if (deb_cnt < DEB_MAX) begin
        deb_cnt <= deb_cnt + 1'b1;
        if (deb_cnt + 1'b1 == DEB_MAX) sw_db <= cand;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a value before any condition, so no latch is inferred.
    limit = 32'(TICK_DIV) >> {sw_db[3:2], 1'b0};
    // A small TICK_DIV at high speed would shift to zero; degrade to a tick every cycle.
    if (limit == 32'd0) limit = 32'd1;
    limit_m1 = limit - 32'd1;
  end

  assign mode_chg = (sw_db[1:0] != mode);
  assign tick     = !sw_db[7] && !mode_chg && (32'(cnt) >= limit_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= ST_ROT_L;
      led      <= 8'h01;
      dir_left <= 1'b1;
      cnt      <= '0;
    end else if (mode_chg) begin
      mode     <= sw_db[1:0];
      led      <= init_pattern(sw_db[1:0]);
      dir_left <= 1'b1;
      cnt      <= '0;
    end else if (tick) begin
      cnt <= '0;
      case (mode)
        ST_ROT_L: begin
          if (!$onehot(led)) led <= 8'h01;
          else               led <= {led[6:0], led[7]};
        end
        ST_ROT_R: begin
          if (!$onehot(led)) led <= 8'h80;
          else               led <= {led[0], led[7:1]};
        end
        ST_BOUNCE: begin
          // Reverse on the step that reaches an end so no value repeats.
          if (!$onehot(led)) begin
            led      <= 8'h01;
            dir_left <= 1'b1;
          end else if (dir_left) begin
            if (led == 8'h80) begin
              dir_left <= 1'b0;
              led      <= 8'h40;
            end else begin
              led <= {led[6:0], 1'b0};
            end
          end else begin
            if (led == 8'h01) begin
              dir_left <= 1'b1;
              led      <= 8'h02;
            end else begin
              led <= {1'b0, led[7:1]};
            end
          end
        end
        default: led <= ~led;
      endcase
    end else if (!sw_db[7]) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Brightness 0..3 enables the top-two-bit phases 0..3: 25/50/75/100% duty.
  assign led_out = led & {8{pwm_cnt[7:6] <= sw_db[5:4]}};
`else
  assign led_out = led;
`endif

  assign ledr = {led_out, sw_db};

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: a pattern-level reference model predicts
// every tick and mode change; a monitor pops and compares as the DUT presents them.
module tb_led_seq_ctrl;

  localparam int TDIV = 8;
  localparam int DEB  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sw  = 8'h00;
  logic [15:0] ledr;
  logic        tick;
  logic [1:0]  mode;

  led_seq_ctrl #(.TICK_DIV(TDIV), .DEB_CYCLES(DEB)) dut (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw),
    .ledr (ledr),
    .tick (tick),
    .mode (mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [1:0] mode;
  } ev_t;

  ev_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Reference model: pattern kept as a bit position / blink phase, not a shift register.
  logic [7:0] m_p1 = 8'h00, m_p2 = 8'h00, m_db = 8'h00;
  logic [7:0] m_hist[$];
  int         m_cnt   = 0;
  logic [1:0] m_mode  = 2'd0;
  int         m_pos   = 0;
  bit         m_right = 1'b0;
  bit         m_on    = 1'b1;
  bit         m_live  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // With PWM the bar may be blanked in the off phase; otherwise it must match exactly.
  task automatic check_led(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
`ifdef LED_PWM_EN
    if (act !== exp && act !== 8'h00) begin
`else
    if (act !== exp) begin
`endif
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic int lim_now();
    int l;
    l = TDIV >> (2 * int'(m_db[3:2]));
    if (l < 1) l = 1;
    return l;
  endfunction

  function automatic logic [7:0] led_of();
    if (m_mode == 2'd3) return m_on ? 8'hFF : 8'h00;
    return 8'(1 << m_pos);
  endfunction

  function automatic bit model_tick();
    return !m_db[7] && (m_db[1:0] == m_mode) && (m_cnt >= lim_now() - 1);
  endfunction

  task automatic model_step(input logic [7:0] s, input logic r);
    ev_t e;
    bit  t;
    bit  same;
    if (r) begin
      m_p1 = 8'h00; m_p2 = 8'h00; m_db = 8'h00;
      m_hist.delete();
      m_cnt = 0; m_mode = 2'd0; m_pos = 0; m_right = 1'b0; m_on = 1'b1;
    end else begin
      t = model_tick();
      if (m_db[1:0] != m_mode) begin
        m_mode = m_db[1:0];
        m_cnt  = 0;
        case (m_mode)
          2'd0: m_pos = 0;
          2'd1: m_pos = 7;
          2'd2: begin m_pos = 0; m_right = 1'b0; end
          default: m_on = 1'b1;
        endcase
        e.led = led_of(); e.mode = m_mode;
        sb_q.push_back(e);
      end else if (t) begin
        m_cnt = 0;
        case (m_mode)
          2'd0: m_pos = (m_pos + 1) % 8;
          2'd1: m_pos = (m_pos + 7) % 8;
          2'd2: begin
            if (!m_right) begin
              if (m_pos == 7) begin m_right = 1'b1; m_pos = 6; end
              else m_pos = m_pos + 1;
            end else begin
              if (m_pos == 0) begin m_right = 1'b0; m_pos = 1; end
              else m_pos = m_pos - 1;
            end
          end
          default: m_on = !m_on;
        endcase
        e.led = led_of(); e.mode = m_mode;
        sb_q.push_back(e);
      end else if (!m_db[7]) begin
        m_cnt = m_cnt + 1;
      end
      // A switch value is accepted once the last DEB synced samples all agree.
      m_hist.push_back(m_p2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      if (m_hist.size() == DEB) begin
        same = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) same = 1'b0;
        if (same) m_db = m_hist[0];
      end
      m_p2 = m_p1;
      m_p1 = s;
    end
  endtask

  // One clock: compare registered outputs against the model, then drive the next inputs.
  task automatic cycle(input logic [7:0] s, input logic r);
    @(negedge clk);
    if (m_live) begin
      check("tick", tick, model_tick());
      check("mode", mode, m_mode);
      check("sw_db", ledr[7:0], m_db);
    end
    sw  = s;
    rst = r;
    model_step(s, r);
    m_live = 1'b1;
  endtask

  initial begin : monitor
    ev_t        e;
    logic       t_s;
    logic [1:0] pm;
    logic       rr;
    forever begin
      @(negedge clk);
      t_s = tick;
      pm  = mode;
      @(posedge clk);
      rr = rst;
      #1;
      if (!rr && m_live && (t_s === 1'b1 || mode !== pm)) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: DUT event with led 0x%0h mode %0d, none expected (t=%0t)",
                   ledr[15:8], mode, $time);
        end else begin
          e = sb_q.pop_front();
          check_led("sb_led", ledr[15:8], e.led);
          check("sb_mode", mode, e.mode);
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] cur;
    logic [7:0] s;
    logic [7:0] gmask;
    logic [7:0] frozen;
    int         glitch;
    int         guard;
    int         lit;

    // Reset
    cycle(8'h00, 1'b1);
    cycle(8'h00, 1'b1);
    check("rst_ledr", ledr, 16'h0100);
    check("rst_tick", tick, 1'b0);
    check("rst_mode", mode, 2'd0);
    for (int i = 0; i < 80; i++) cycle(8'h00, 1'b0);

    // Debounce: a 3-cycle pulse is rejected, a held value is accepted
    for (int i = 0; i < 3; i++) cycle(8'h01, 1'b0);
    for (int i = 0; i < 8; i++) cycle(8'h00, 1'b0);
    check("deb_glitch", ledr[7:0], 8'h00);
    for (int i = 0; i < 7; i++) cycle(8'h01, 1'b0);
    check("deb_accept", ledr[7:0], 8'h01);
    cycle(8'h01, 1'b0);
    check("deb_mode", mode, 2'd1);
    check_led("deb_init", ledr[15:8], 8'h80);
    for (int i = 0; i < 7; i++) cycle(8'h01, 1'b0);
    check_led("deb_hold", ledr[15:8], 8'h80);
    cycle(8'h01, 1'b0);
    check_led("deb_step", ledr[15:8], 8'h40);

    // Bounce through both ends
    for (int i = 0; i < 140; i++) cycle(8'h02, 1'b0);

    // Speed change with cnt already past the new limit
    for (int i = 0; i < 20; i++) cycle(8'h00, 1'b0);
    guard = 0;
    while (!(m_cnt == 0 && m_db == 8'h00 && m_mode == 2'd0) && guard < 16) begin
      cycle(8'h00, 1'b0);
      guard++;
    end
    if (guard >= 16) fail_bound("speed_align");
    for (int i = 0; i < 7; i++) cycle(8'h04, 1'b0);
    check("speed_db", ledr[7:0], 8'h04);
    check("speed_tick_now", tick, 1'b1);
    cycle(8'h04, 1'b0);
    check("speed_tick_gap", tick, 1'b0);
    cycle(8'h04, 1'b0);
    check("speed_tick_next", tick, 1'b1);

    // Mode change coinciding with a due tick
    for (int i = 0; i < 20; i++) cycle(8'h00, 1'b0);
    guard = 0;
    while (!(m_cnt == 1 && m_db == 8'h00 && m_mode == 2'd0) && guard < 16) begin
      cycle(8'h00, 1'b0);
      guard++;
    end
    if (guard >= 16) fail_bound("coinc_align");
    for (int i = 0; i < 7; i++) cycle(8'h01, 1'b0);
    check("coinc_tick_suppr", tick, 1'b0);
    cycle(8'h01, 1'b0);
    check("coinc_mode", mode, 2'd1);
    check_led("coinc_init", ledr[15:8], 8'h80);

    // Pause freezes the pattern; mode changes still apply
    for (int i = 0; i < 10; i++) cycle(8'h81, 1'b0);
    frozen = led_of();
    for (int i = 0; i < 24; i++) cycle(8'h81, 1'b0);
    check_led("pause_frozen", ledr[15:8], frozen);
    for (int i = 0; i < 8; i++) cycle(8'h83, 1'b0);
    check("pause_mode", mode, 2'd3);
    check_led("pause_blink_init", ledr[15:8], 8'hFF);
    for (int i = 0; i < 30; i++) cycle(8'h03, 1'b0);

    // Randomized switch activity with glitches and one mid-run reset
    cur = 8'h03;
    glitch = 0;
    gmask = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0)
        cur = {($urandom_range(0, 7) == 0), 1'($urandom), 2'($urandom),
               1'b0, 1'($urandom), 2'($urandom)};
      if (glitch == 0 && $urandom_range(0, 49) == 0) begin
        glitch = $urandom_range(1, 3);
        gmask  = 8'(1 << $urandom_range(0, 7));
      end
      s = cur;
      if (glitch > 0) begin
        s = cur ^ gmask;
        glitch--;
      end
      cycle(s, (i == 700 || i == 701) ? 1'b1 : 1'b0);
    end

`ifdef LED_PWM_EN
    for (int i = 0; i < 20; i++) cycle(8'h10, 1'b0);
    lit = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(8'h10, 1'b0);
      if (ledr[15:8] != 8'h00) lit++;
    end
    check("pwm_b1_duty", lit, 128);
    for (int i = 0; i < 20; i++) cycle(8'h30, 1'b0);
    lit = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(8'h30, 1'b0);
      if (ledr[15:8] != 8'h00) lit++;
    end
    check("pwm_b3_duty", lit, 256);
`else
    lit = 0;
`endif

    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0);
    @(posedge clk);
    #2;
    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
